mc_datapath: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle datapath top.
- Accepts one 32-bit MIPS-format instruction per handshake, sequences it through an internal control FSM, and executes it over 3–5 cycles.
- Contains a parametrised register file, ALU, word-addressed data memory, and the IR/A/B/ALUOut/MDR holding registers.
- Sits between an external fetch unit (valid/ready instruction source) and branch/PC logic (branch outputs).

---
 rtl/mc_pkg.sv | 39 +++
 rtl/mc_ctrl_fsm.sv | 142 ++++++++++++++
 rtl/mc_datapath.sv | 135 +++++++++++++
 tb/tb_mc_datapath.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset datapath: opcodes, funct
// codes, instruction field positions, ALU operations and control states.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int IMM_W  = 16;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Control sequencer: walks each accepted instruction through DECODE/EXEC/MEM/WB
// and produces datapath enables, mux selects and completion pulses.
module mc_ctrl_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       instr_valid,
  input  logic       alu_zero,
  output alu_op_e    alu_op,
  output logic       alu_src_imm,
  output logic       reg_dst_rd,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       mem_write,
  output logic       ir_en,
  output logic       ab_en,
  output logic       aluout_en,
  output logic       mdr_en,
  output logic       instr_ready,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       branch_taken
);

  state_e  state_r, state_nx_s;
  alu_op_e r_op_s;
  logic    r_legal_s, is_r_s, is_addi_s, is_lw_s, is_sw_s, is_beq_s, legal_s;

  // Instruction class and ALU operation decode from the held IR
  always_comb begin
    r_op_s    = ALU_ADD;
    r_legal_s = 1'b1;
    case (funct)
      FN_ADD:  r_op_s = ALU_ADD;
      FN_SUB:  r_op_s = ALU_SUB;
      FN_AND:  r_op_s = ALU_AND;
      FN_OR:   r_op_s = ALU_OR;
      FN_SLT:  r_op_s = ALU_SLT;
      default: r_legal_s = 1'b0;
    endcase
    is_r_s    = (opcode == OP_RTYPE);
    is_addi_s = (opcode == OP_ADDI);
    is_lw_s   = (opcode == OP_LW);
    is_sw_s   = (opcode == OP_SW);
    is_beq_s  = (opcode == OP_BEQ);
    legal_s   = (is_r_s && r_legal_s) || is_addi_s || is_lw_s || is_sw_s || is_beq_s;
    if (is_r_s) begin
      alu_op = r_op_s;
    end else if (is_beq_s) begin
      alu_op = ALU_SUB;
    end else begin
      alu_op = ALU_ADD;
    end
    alu_src_imm = !(is_r_s || is_beq_s);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and per-state control outputs
  always_comb begin
    state_nx_s   = state_r;
    instr_ready  = 1'b0;
    busy         = 1'b1;
    ir_en        = 1'b0;
    ab_en        = 1'b0;
    aluout_en    = 1'b0;
    mdr_en       = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    reg_dst_rd   = 1'b0;
    mem_to_reg   = 1'b0;
    done         = 1'b0;
    illegal      = 1'b0;
    branch_taken = 1'b0;
    case (state_r)
      ST_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) begin
          ir_en      = 1'b1;
          state_nx_s = ST_DECODE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_DECODE: begin
        ab_en = 1'b1;
        if (legal_s) begin
          state_nx_s = ST_EXEC;
        end else begin
          illegal    = 1'b1;
          done       = 1'b1;
          state_nx_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        aluout_en = 1'b1;
        if (is_beq_s) begin
          done         = 1'b1;
          branch_taken = alu_zero;
          state_nx_s   = ST_IDLE;
        end else if (is_lw_s || is_sw_s) begin
          state_nx_s = ST_MEM;
        end else begin
          state_nx_s = ST_WB;
        end
      end
      ST_MEM: begin
        if (is_sw_s) begin
          mem_write  = 1'b1;
          done       = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          mdr_en     = 1'b1;
          state_nx_s = ST_WB;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst_rd = is_r_s;
        mem_to_reg = is_lw_s;
        done       = 1'b1;
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset datapath: register file, ALU, word-addressed data
// memory and IR/A/B/ALUOut/MDR holding registers, sequenced by mc_ctrl_fsm.
module mc_datapath
  import mc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int DMEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic            iszero,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_offset,
  output logic [XLEN-1:0] result
);

  localparam int RW = $clog2(NREG);
  localparam int AW = $clog2(DMEM_DEPTH);

  logic [31:0]     ir_r;
  logic [XLEN-1:0] a_r, b_r, aluout_r, mdr_r, result_r;
  logic            iszero_r;
  logic [XLEN-1:0] rf_r   [NREG];
  logic [XLEN-1:0] dmem_r [DMEM_DEPTH];

  alu_op_e         alu_op_s;
  logic            alu_src_imm_s, reg_dst_rd_s, mem_to_reg_s, reg_write_s, mem_write_s;
  logic            ir_en_s, ab_en_s, aluout_en_s, mdr_en_s, alu_zero_s;
  logic [RW-1:0]   rs_idx_s, rt_idx_s, rd_idx_s, wb_idx_s;
  logic [AW-1:0]   addr_s;
  logic [XLEN-1:0] imm_sext_s, alu_b_s, alu_res_s, wb_data_s;

  mc_ctrl_fsm u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .opcode       (ir_r[OP_LSB +: 6]),
    .funct        (ir_r[5:0]),
    .instr_valid  (instr_valid),
    .alu_zero     (alu_zero_s),
    .alu_op       (alu_op_s),
    .alu_src_imm  (alu_src_imm_s),
    .reg_dst_rd   (reg_dst_rd_s),
    .mem_to_reg   (mem_to_reg_s),
    .reg_write    (reg_write_s),
    .mem_write    (mem_write_s),
    .ir_en        (ir_en_s),
    .ab_en        (ab_en_s),
    .aluout_en    (aluout_en_s),
    .mdr_en       (mdr_en_s),
    .instr_ready  (instr_ready),
    .busy         (busy),
    .done         (done),
    .illegal      (illegal),
    .branch_taken (branch_taken)
  );

  // Narrow register indices alias when NREG < 32
  assign rs_idx_s   = ir_r[RS_LSB +: RW];
  assign rt_idx_s   = ir_r[RT_LSB +: RW];
  assign rd_idx_s   = ir_r[RD_LSB +: RW];
  assign imm_sext_s = {{(XLEN-IMM_W){ir_r[IMM_W-1]}}, ir_r[IMM_W-1:0]};
  assign alu_b_s    = alu_src_imm_s ? imm_sext_s : b_r;
  assign alu_zero_s = (alu_res_s == {XLEN{1'b0}});
  assign addr_s     = aluout_r[AW+1:2];
  assign wb_idx_s   = reg_dst_rd_s ? rd_idx_s : rt_idx_s;
  assign wb_data_s  = mem_to_reg_s ? mdr_r : aluout_r;

  assign iszero        = iszero_r;
  assign result        = result_r;
  assign branch_offset = branch_taken ? {imm_sext_s[XLEN-3:0], 2'b00} : {XLEN{1'b0}};

  // ALU
  always_comb begin
    case (alu_op_s)
      ALU_ADD: alu_res_s = a_r + alu_b_s;
      ALU_SUB: alu_res_s = a_r - alu_b_s;
      ALU_AND: alu_res_s = a_r & alu_b_s;
      ALU_OR:  alu_res_s = a_r | alu_b_s;
      ALU_SLT: alu_res_s = {{(XLEN-1){1'b0}}, ($signed(a_r) < $signed(alu_b_s))};
      default: alu_res_s = {XLEN{1'b0}};
    endcase
  end

  // Holding registers, register file and debug result
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_r     <= 32'd0;
      a_r      <= {XLEN{1'b0}};
      b_r      <= {XLEN{1'b0}};
      aluout_r <= {XLEN{1'b0}};
      mdr_r    <= {XLEN{1'b0}};
      result_r <= {XLEN{1'b0}};
      iszero_r <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        rf_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      if (ir_en_s) begin
        ir_r <= instr;
      end
      if (ab_en_s) begin
        a_r <= rf_r[rs_idx_s];
        b_r <= rf_r[rt_idx_s];
      end
      if (aluout_en_s) begin
        aluout_r <= alu_res_s;
        iszero_r <= alu_zero_s;
      end
      if (mdr_en_s) begin
        mdr_r <= dmem_r[addr_s];
      end
      if (reg_write_s) begin
        result_r <= wb_data_s;
        if (wb_idx_s != {RW{1'b0}}) begin
          rf_r[wb_idx_s] <= wb_data_s;
        end
      end
    end
  end

  // Data memory keeps its contents across reset; a reset cycle blocks the store
  always_ff @(posedge clk) begin
    if (!rst && mem_write_s) begin
      dmem_r[addr_s] <= b_r;
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: directed program plus random instruction
// stream checked against an instruction-level reference model.
module tb_mc_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready, busy, done, illegal, iszero, branch_taken;
  logic [31:0] branch_offset, result;

  always #5 clk = ~clk;

  mc_datapath #(.XLEN(32), .NREG(32), .DMEM_DEPTH(256)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .busy          (busy),
    .done          (done),
    .illegal       (illegal),
    .iszero        (iszero),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .result        (result)
  );

  typedef struct {
    int          lat;
    bit          ill;
    bit          bt;
    logic [31:0] boff;
    bit          wr;
    logic [31:0] res;
    bit          chkz;
    bit          z;
  } exp_t;

  exp_t        sbq[$];
  exp_t        me;
  logic [31:0] rf_m[32];
  logic [31:0] dm_m[int];
  logic [5:0]  fns[5];
  int          checks = 0, passes = 0;
  int          cyc = 0, acc_cyc = 0, accepts = 0, issued = 0;
  bit          pend_res = 1'b0;
  logic [31:0] pend_val;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Instruction-level reference: architectural effect plus expected latency
  function automatic exp_t model(input logic [31:0] ins);
    exp_t        e;
    logic [5:0]  op, fn;
    int          rs, rt, rd, idx;
    logic [31:0] a, b, sx, r;
    op = ins[31:26]; fn = ins[5:0];
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    sx = {{16{ins[15]}}, ins[15:0]};
    a = rf_m[rs]; b = rf_m[rt]; r = 32'd0;
    e.lat = 1; e.ill = 1'b0; e.bt = 1'b0; e.boff = 32'd0;
    e.wr = 1'b0; e.res = 32'd0; e.chkz = 1'b0; e.z = 1'b0;
    case (op)
      6'h00: begin
        e.lat = 3; e.wr = 1'b1; e.chkz = 1'b1;
        case (fn)
          6'h20: r = a + b;
          6'h22: r = a - b;
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin e.ill = 1'b1; e.lat = 1; e.wr = 1'b0; e.chkz = 1'b0; end
        endcase
        if (!e.ill) begin
          e.res = r; e.z = (r == 32'd0);
          if (rd != 0) rf_m[rd] = r;
        end
      end
      6'h08: begin
        r = a + sx; e.lat = 3; e.wr = 1'b1; e.res = r; e.chkz = 1'b1; e.z = (r == 32'd0);
        if (rt != 0) rf_m[rt] = r;
      end
      6'h23: begin
        r = a + sx; idx = int'(r[9:2]);
        e.lat = 4; e.wr = 1'b1; e.res = dm_m[idx]; e.chkz = 1'b1; e.z = (r == 32'd0);
        if (rt != 0) rf_m[rt] = dm_m[idx];
      end
      6'h2B: begin
        r = a + sx; idx = int'(r[9:2]);
        dm_m[idx] = b; e.lat = 3; e.chkz = 1'b1; e.z = (r == 32'd0);
      end
      6'h04: begin
        e.lat = 2; e.bt = (a == b);
        e.boff = e.bt ? (sx << 2) : 32'd0;
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] gen();
    int          k, rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] addr, ins;
    logic [5:0]  op;
    k = $urandom_range(0, 9);
    rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
    imm = 16'($urandom);
    ins = 32'd0;
    case (k)
      0, 1, 2, 3: ins = r_ins(fns[$urandom_range(0, 4)], rs, rt, rd);
      4:          ins = i_ins(6'h08, rs, rt, imm);
      5:          ins = i_ins(6'h2B, rs, rt, imm);
      6: begin
        addr = rf_m[rs] + {{16{imm[15]}}, imm};
        if (dm_m.exists(int'(addr[9:2]))) ins = i_ins(6'h23, rs, rt, imm);
        else ins = i_ins(6'h2B, rs, rt, imm);
      end
      7: ins = i_ins(6'h04, rs, ($urandom_range(0, 1) == 0) ? rs : rt, imm);
      8: begin
        do op = 6'($urandom); while (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04);
        ins = i_ins(op, rs, rt, imm);
      end
      default: ins = r_ins(6'($urandom_range(0, 15)), rs, rt, rd);
    endcase
    return ins;
  endfunction

  // Monitor: pops the scoreboard on each done pulse
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend_res = 1'b0;
    end else begin
      if (pend_res) begin
        chk("result", result, pend_val);
        pend_res = 1'b0;
      end
      chk("ready_vs_busy", 32'(instr_ready), 32'(!busy));
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          me = sbq.pop_front();
          chk("latency", 32'(cyc - acc_cyc), 32'(me.lat));
          chk("illegal", 32'(illegal), 32'(me.ill));
          chk("branch_taken", 32'(branch_taken), 32'(me.bt));
          chk("branch_offset", branch_offset, me.boff);
          if (me.chkz) chk("iszero", 32'(iszero), 32'(me.z));
          if (me.wr) begin pend_res = 1'b1; pend_val = me.res; end
        end
      end else begin
        chk("stray_pulse", {30'd0, illegal, branch_taken}, 32'd0);
      end
      if (instr_valid && instr_ready) begin
        acc_cyc = cyc;
        accepts++;
      end
    end
  end

  task automatic issue(input logic [31:0] ins);
    exp_t e;
    int   n;
    e = model(ins);
    instr = ins;
    instr_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!instr_ready && n < 60);
    if (!instr_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
    end else begin
      sbq.push_back(e);
      issued++;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    instr_valid = 1'b0;
    while ((sbq.size() != 0 || busy) && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    sbq.delete();
  endtask

  initial begin
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
    instr = 32'd0;
    do_reset();
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_iszero", 32'(iszero), 32'd0);
    @(posedge clk); #1;

    issue(i_ins(6'h08, 0, 1, 16'd5));
    issue(i_ins(6'h08, 0, 2, 16'd7));
    issue(r_ins(6'h22, 1, 2, 3));
    issue(r_ins(6'h2A, 3, 1, 4));
    issue(i_ins(6'h2B, 0, 2, 16'd8));
    issue(i_ins(6'h23, 0, 5, 16'd8));
    issue(i_ins(6'h23, 0, 6, 16'd1032));
    issue(i_ins(6'h04, 1, 1, 16'hFFFD));
    issue(i_ins(6'h04, 1, 2, 16'h0005));
    issue(i_ins(6'h08, 0, 0, 16'd9));
    issue({6'h3F, 26'h0});
    issue(r_ins(6'h21, 1, 2, 7));
    drain();
    chk("R0", dut.rf_r[0], 32'd0);
    chk("R1", dut.rf_r[1], 32'd5);
    chk("R3", dut.rf_r[3], 32'hFFFFFFFE);
    chk("R4", dut.rf_r[4], 32'd1);
    chk("R5", dut.rf_r[5], 32'd7);
    chk("R6", dut.rf_r[6], 32'd7);
    chk("R7", dut.rf_r[7], 32'd0);

    for (int i = 0; i < 400; i++) issue(gen());
    drain();
    for (int i = 0; i < 32; i++) chk($sformatf("rf%0d", i), dut.rf_r[i], rf_m[i]);
    chk("accepts", 32'(accepts), 32'(issued));

    // Reset lands on the edge that ends LW's EXEC cycle
    instr = i_ins(6'h23, 0, 5, 16'd8);
    instr_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 instr_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    @(negedge clk);
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", result, 32'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("abort_rf%0d", i), dut.rf_r[i], 32'd0);
    @(posedge clk); #1;
    issue(i_ins(6'h23, 0, 7, 16'd8));
    drain();
    chk("dmem_kept", dut.rf_r[7], dm_m[2]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
